rf_multiport: RTL and testbench

Parametrised general-purpose register file for the pipelined datapath. It has N combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass, and a per-register busy scoreboard. The scoreboard tracks destinations issued but not yet written back. Sits in the decode stage: read ports feed operand selection, the write port is driven by writeback, and the issue port is driven by hazard control.

---
 rtl/rf_multiport.sv | 85 ++++++++
 tb/tb_rf_multiport.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-port register file with one synchronous write port, optional same-cycle
// write-to-read forwarding, and a per-register busy scoreboard with a live busy count.
module rf_multiport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      curr_pc,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] read_result,
    output logic [READ_PORTS-1:0]            read_busy,
    input  logic                             write_enable,
    input  logic [ADDR_WIDTH-1:0]            write_addr,
    input  logic [DATA_WIDTH-1:0]            write_data,
    input  logic                             issue_enable,
    input  logic [ADDR_WIDTH-1:0]            issue_addr,
    output logic [ADDR_WIDTH:0]              busy_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_hit;
    logic                  is_hit;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic                  unused_pc;

    // curr_pc only identifies the writer for simulation-side tracing.
    assign unused_pc = ^curr_pc;

    assign wr_hit = write_enable && (write_addr != '0);
    assign is_hit = issue_enable && (issue_addr != '0);

    // Net change of the busy vector this cycle: a new producer on an idle register
    // adds one; a write retiring a busy register removes one unless re-issued now.
    assign cnt_inc = is_hit && !busy[issue_addr];
    assign cnt_dec = wr_hit && busy[write_addr] && !(is_hit && (issue_addr == write_addr));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            count <= '0;
        end else begin
            if (wr_hit) begin
                regs[write_addr] <= write_data;
                busy[write_addr] <= 1'b0;
            end
            // Placed after the write so a same-address issue leaves the register busy.
            if (is_hit) begin
                busy[issue_addr] <= 1'b1;
            end
            if (cnt_inc && !cnt_dec) begin
                count <= count + 1'b1;
            end else if (cnt_dec && !cnt_inc) begin
                count <= count - 1'b1;
            end
        end
    end

    assign busy_count = count;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic                  fwd;
        logic                  nonzero;

        assign addr    = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign nonzero = (addr != '0);
        assign fwd     = (BYPASS != 0) && wr_hit && (write_addr == addr);

        assign read_result[p*DATA_WIDTH +: DATA_WIDTH] =
            !nonzero ? '0 : (fwd ? write_data : regs[addr]);
        assign read_busy[p] = nonzero && busy[addr] && !fwd;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed vector table plus hand sequences for rf_multiport, and a randomized
// 4-port / 8-entry instance checked against a reference model every cycle.
module tb_rf_multiport;

    logic        clk;
    logic        rst;
    logic [31:0] curr_pc;
    logic [9:0]  read_addr;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        issue_enable;
    logic [4:0]  issue_addr;

    logic [63:0] by_result;
    logic [1:0]  by_busy;
    logic [5:0]  by_count;
    logic [63:0] nb_result;
    logic [1:0]  nb_busy;
    logic [5:0]  nb_count;

    logic         c_rst;
    logic [11:0]  c_read_addr;
    logic [127:0] c_result;
    logic [3:0]   c_busy;
    logic [3:0]   c_count;
    logic         c_we;
    logic [2:0]   c_wa;
    logic [31:0]  c_wd;
    logic         c_ie;
    logic [2:0]   c_ia;

    int n_vec  = 0;
    int n_fail = 0;

    rf_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(1)) u_by (
        .clk(clk), .rst(rst), .curr_pc(curr_pc), .read_addr(read_addr),
        .read_result(by_result), .read_busy(by_busy), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .issue_enable(issue_enable),
        .issue_addr(issue_addr), .busy_count(by_count)
    );

    rf_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .curr_pc(curr_pc), .read_addr(read_addr),
        .read_result(nb_result), .read_busy(nb_busy), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .issue_enable(issue_enable),
        .issue_addr(issue_addr), .busy_count(nb_count)
    );

    rf_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .READ_PORTS(4), .BYPASS(1)) u_rnd (
        .clk(clk), .rst(c_rst), .curr_pc(curr_pc), .read_addr(c_read_addr),
        .read_result(c_result), .read_busy(c_busy), .write_enable(c_we),
        .write_addr(c_wa), .write_data(c_wd), .issue_enable(c_ie),
        .issue_addr(c_ia), .busy_count(c_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eb, input logic [5:0] ec);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: apply inputs at negedge, outputs settle before the next posedge
    task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        @(negedge clk);
        rst = r; write_enable = we; write_addr = wa; write_data = wd;
        issue_enable = ie; issue_addr = ia; read_addr = {ra1, ra0};
        curr_pc = curr_pc + 32'd4;
        #2;
    endtask

    // reference model for the randomized instance
    logic [31:0] m_regs [8];
    logic [7:0]  m_busy;

    initial begin
        rst = 1'b1; c_rst = 1'b1; curr_pc = 32'h1000; read_addr = '0;
        write_enable = 1'b0; write_addr = '0; write_data = '0;
        issue_enable = 1'b0; issue_addr = '0;
        c_read_addr = '0; c_we = 1'b0; c_wa = '0; c_wd = '0; c_ie = 1'b0; c_ia = '0;
        repeat (2) @(posedge clk);

        //            rst we wa  wd            ie ia  ra0 ra1 e0            e1        eb     ec
        vecs[0]  = mk(0, 0, 0,  32'h0,        0, 0,  5,  31, 32'h0,        32'h0,    2'b00, 6'd0);
        vecs[1]  = mk(0, 1, 7,  32'hDEADBEEF, 0, 0,  7,  0,  32'hDEADBEEF, 32'h0,    2'b00, 6'd0);
        vecs[2]  = mk(0, 0, 0,  32'h0,        0, 0,  7,  0,  32'hDEADBEEF, 32'h0,    2'b00, 6'd0);
        vecs[3]  = mk(0, 0, 0,  32'h0,        1, 3,  3,  4,  32'h0,        32'h0,    2'b00, 6'd0);
        vecs[4]  = mk(0, 0, 0,  32'h0,        1, 4,  3,  4,  32'h0,        32'h0,    2'b01, 6'd1);
        vecs[5]  = mk(0, 1, 3,  32'h33,       0, 0,  3,  4,  32'h33,       32'h0,    2'b10, 6'd2);
        vecs[6]  = mk(0, 0, 0,  32'h0,        0, 0,  3,  4,  32'h33,       32'h0,    2'b10, 6'd1);
        vecs[7]  = mk(0, 1, 9,  32'h12,       1, 9,  9,  4,  32'h12,       32'h0,    2'b10, 6'd1);
        vecs[8]  = mk(0, 0, 0,  32'h0,        0, 0,  9,  4,  32'h12,       32'h0,    2'b11, 6'd2);
        vecs[9]  = mk(0, 1, 0,  32'hFF,       1, 0,  0,  9,  32'h0,        32'h12,   2'b10, 6'd2);
        vecs[10] = mk(0, 0, 0,  32'h0,        0, 0,  0,  9,  32'h0,        32'h12,   2'b10, 6'd2);
        vecs[11] = mk(0, 0, 0,  32'h0,        1, 4,  4,  9,  32'h0,        32'h12,   2'b11, 6'd2);
        vecs[12] = mk(0, 1, 31, 32'hA5A5,     0, 0,  31, 4,  32'hA5A5,     32'h0,    2'b10, 6'd2);
        vecs[13] = mk(0, 0, 0,  32'h0,        0, 0,  31, 4,  32'hA5A5,     32'h0,    2'b10, 6'd2);
        vecs[14] = mk(0, 1, 4,  32'h44,       1, 10, 4,  10, 32'h44,       32'h0,    2'b00, 6'd2);
        vecs[15] = mk(0, 0, 0,  32'h0,        0, 0,  4,  10, 32'h44,       32'h0,    2'b10, 6'd2);
        vecs[16] = mk(1, 1, 10, 32'h55,       0, 0,  10, 9,  32'h55,       32'h12,   2'b10, 6'd2);
        vecs[17] = mk(0, 0, 0,  32'h0,        0, 0,  10, 9,  32'h0,        32'h0,    2'b00, 6'd0);
        vecs[18] = mk(0, 0, 0,  32'h0,        0, 0,  7,  3,  32'h0,        32'h0,    2'b00, 6'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ie, vecs[i].ia, vecs[i].ra0, vecs[i].ra1);
            check($sformatf("v%0d result0", i), by_result[31:0], vecs[i].e0);
            check($sformatf("v%0d result1", i), by_result[63:32], vecs[i].e1);
            check($sformatf("v%0d busy", i), by_busy, vecs[i].eb);
            check($sformatf("v%0d busy_count", i), by_count, vecs[i].ec);
        end

        // no-forwarding instance: old value during the write cycle, new value after
        drive(0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0);
        check("nb write-cycle result0", nb_result[31:0], 32'h0);
        check("by write-cycle result0", by_result[31:0], 32'hDEADBEEF);
        drive(0, 0, 0, 32'h0, 1, 5, 7, 5);
        check("nb next-cycle result0", nb_result[31:0], 32'hDEADBEEF);
        drive(0, 1, 5, 32'h5555, 0, 0, 5, 5);
        check("nb write-cycle busy", nb_busy, 2'b11);
        check("by write-cycle busy", by_busy, 2'b00);
        check("nb write-cycle count", nb_count, 6'd1);
        drive(0, 0, 0, 32'h0, 0, 0, 5, 7);
        check("nb after-write busy", nb_busy, 2'b00);
        check("nb after-write count", nb_count, 6'd0);
        check("nb after-write result0", nb_result[31:0], 32'h5555);

        // randomized 4-port instance against the model
        @(negedge clk);
        c_rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_busy = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            c_rst = ($urandom_range(0, 99) == 0);
            c_we  = $urandom_range(0, 1);
            c_wa  = 3'($urandom_range(0, 7));
            c_wd  = $urandom;
            c_ie  = $urandom_range(0, 1);
            c_ia  = 3'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++) c_read_addr[p*3 +: 3] = 3'($urandom_range(0, 7));
            #2;
            for (int p = 0; p < 4; p++) begin
                logic [2:0]  a;
                logic        fwd;
                logic [31:0] er;
                logic        eb;
                a   = c_read_addr[p*3 +: 3];
                fwd = c_we && (c_wa != 0) && (c_wa == a);
                er  = (a == 0) ? 32'h0 : (fwd ? c_wd : m_regs[a]);
                eb  = (a != 0) && m_busy[a] && !fwd;
                check($sformatf("rnd c%0d p%0d result", cyc, p), c_result[p*32 +: 32], er);
                check($sformatf("rnd c%0d p%0d busy", cyc, p), c_busy[p], eb);
            end
            check($sformatf("rnd c%0d busy_count", cyc), c_count, 4'($countones(m_busy)));
            @(posedge clk);
            if (c_rst) begin
                for (int i = 0; i < 8; i++) m_regs[i] = '0;
                m_busy = '0;
            end else begin
                if (c_we && c_wa != 0) begin
                    m_regs[c_wa] = c_wd;
                    m_busy[c_wa] = 1'b0;
                end
                if (c_ie && c_ia != 0) m_busy[c_ia] = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
